// File: rtl/sys_ctrl_cmd_pkg.sv
// Shared types for the command-frame controller: byte frames, ALU opcodes, command codes, FSM states.
// Pure declarations; no latency or backpressure of its own.
package sys_ctrl_cmd_pkg;

    typedef logic [7:0]  dataframe_t;
    typedef logic [15:0] result_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MULT = 4'd2,
        OP_DIV  = 4'd3,
        OP_MOD  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_XOR  = 4'd7,
        OP_NOT  = 4'd8,
        OP_NAND = 4'd9,
        OP_NOR  = 4'd10,
        OP_XNOR = 4'd11,
        OP_SR   = 4'd12,
        OP_SL   = 4'd13
    } opcode_t;

    localparam dataframe_t CMD_WR      = 8'hAA;
    localparam dataframe_t CMD_RD      = 8'hBB;
    localparam dataframe_t CMD_ALU_OP  = 8'hCC;
    localparam dataframe_t CMD_ALU_NOP = 8'hDD;

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_OPC, ALU_WAIT, TX_LO, TX_HI
    } ctrl_state_t;

    function automatic logic is_legal_op(dataframe_t d);
        return (d[7:4] == 4'h0) && (d[3:0] <= 4'd13);
    endfunction

endpackage

// File: rtl/sys_ctrl_cmd_if.sv
// Bundle of the rx byte strobe, ALU request/result and tx valid/ready signals around the controller.
// master = controller side, slave = link/ALU side.
interface sys_ctrl_cmd_if;
    import sys_ctrl_cmd_pkg::*;

    dataframe_t rx_data;
    logic       rx_valid;
    dataframe_t alu_a;
    dataframe_t alu_b;
    opcode_t    alu_op;
    logic       alu_en;
    result_t    alu_result;
    logic       alu_result_valid;
    dataframe_t tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       cmd_err;
    logic       busy;

    modport master (
        input  rx_data, rx_valid, alu_result, alu_result_valid, tx_ready,
        output alu_a, alu_b, alu_op, alu_en, tx_data, tx_valid, cmd_err, busy
    );

    modport slave (
        output rx_data, rx_valid, alu_result, alu_result_valid, tx_ready,
        input  alu_a, alu_b, alu_op, alu_en, tx_data, tx_valid, cmd_err, busy
    );

endinterface

// File: rtl/sys_reg_bank.sv
// Operand/scratch register bank: one write port, combinational read, reg0/reg1 taps.
// Write lands on the next edge, read is same-cycle; no backpressure.
module sys_reg_bank
    import sys_ctrl_cmd_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  dataframe_t    wr_data,
    input  logic [AW-1:0] rd_addr,
    output dataframe_t    rd_data,
    output dataframe_t    reg0,
    output dataframe_t    reg1
);

    dataframe_t regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data = regs[rd_addr];
    assign reg0    = regs[0];
    assign reg1    = regs[1];

endmodule

// File: rtl/sys_ctrl_cmd.sv
// Command-frame sequencer between the serial link, register bank and ALU; one byte consumed per rx_valid.
// alu_en one cycle after the opcode byte; tx_valid held until tx_ready, stray rx bytes while busy are dropped with cmd_err.
module sys_ctrl_cmd
    import sys_ctrl_cmd_pkg::*;
#(
    parameter int NUM_REGS    = 4,
    parameter int ALU_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    sys_ctrl_cmd_if.master bus
);

    localparam int AW = $clog2(NUM_REGS);
    localparam int TW = $clog2(ALU_TIMEOUT + 1);

    ctrl_state_t   state;
    logic [AW-1:0] addr_q;
    logic          rd_q;
    dataframe_t    res_hi_q;
    logic [TW-1:0] tmo_cnt;

    dataframe_t    alu_a_q, alu_b_q, tx_data_q;
    opcode_t       alu_op_q;
    logic          alu_en_q, tx_valid_q, cmd_err_q;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    dataframe_t    rd_data, reg0, reg1;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        if (bus.rx_valid) begin
            case (state)
                WR_DATA: begin wr_en = 1'b1; wr_addr = addr_q;   end
                ALU_A:   begin wr_en = 1'b1; wr_addr = AW'(0);   end
                ALU_B:   begin wr_en = 1'b1; wr_addr = AW'(1);   end
                default: ;
            endcase
        end
    end

    sys_reg_bank #(.NUM_REGS(NUM_REGS), .AW(AW)) u_reg_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (bus.rx_data),
        .rd_addr (bus.rx_data[AW-1:0]),
        .rd_data (rd_data),
        .reg0    (reg0),
        .reg1    (reg1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            res_hi_q   <= '0;
            tmo_cnt    <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= OP_ADD;
            alu_en_q   <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            alu_en_q  <= 1'b0;
            cmd_err_q <= 1'b0;
            case (state)
                IDLE: if (bus.rx_valid) begin
                    case (bus.rx_data)
                        CMD_WR:      state <= WR_ADDR;
                        CMD_RD:      state <= RD_ADDR;
                        CMD_ALU_OP:  state <= ALU_A;
                        CMD_ALU_NOP: state <= ALU_OPC;
                        default:     cmd_err_q <= 1'b1;
                    endcase
                end
                WR_ADDR: if (bus.rx_valid) begin
                    addr_q <= bus.rx_data[AW-1:0];
                    state  <= WR_DATA;
                end
                WR_DATA: if (bus.rx_valid) state <= IDLE;
                RD_ADDR: if (bus.rx_valid) begin
                    tx_data_q  <= rd_data;
                    tx_valid_q <= 1'b1;
                    rd_q       <= 1'b1;
                    state      <= TX_LO;
                end
                ALU_A: if (bus.rx_valid) state <= ALU_B;
                ALU_B: if (bus.rx_valid) state <= ALU_OPC;
                ALU_OPC: if (bus.rx_valid) begin
                    if (is_legal_op(bus.rx_data)) begin
                        alu_a_q  <= reg0;
                        alu_b_q  <= reg1;
                        alu_op_q <= opcode_t'(bus.rx_data[3:0]);
                        alu_en_q <= 1'b1;
                        tmo_cnt  <= '0;
                        rd_q     <= 1'b0;
                        state    <= ALU_WAIT;
                    end else begin
                        cmd_err_q <= 1'b1;
                        state     <= IDLE;
                    end
                end
                ALU_WAIT: begin
                    // A result arriving on the timeout cycle takes priority and suppresses the error.
                    if (bus.alu_result_valid) begin
                        tx_data_q  <= bus.alu_result[7:0];
                        res_hi_q   <= bus.alu_result[15:8];
                        tx_valid_q <= 1'b1;
                        state      <= TX_LO;
                    end else if (tmo_cnt == TW'(ALU_TIMEOUT - 1)) begin
                        tx_data_q  <= 8'hFF;
                        res_hi_q   <= 8'hFF;
                        tx_valid_q <= 1'b1;
                        cmd_err_q  <= 1'b1;
                        state      <= TX_LO;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                TX_LO: if (tx_valid_q && bus.tx_ready) begin
                    if (rd_q) begin
                        tx_valid_q <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        tx_data_q <= res_hi_q;
                        state     <= TX_HI;
                    end
                end
                TX_HI: if (tx_valid_q && bus.tx_ready) begin
                    tx_valid_q <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (bus.rx_valid && (state == ALU_WAIT || state == TX_LO || state == TX_HI))
                cmd_err_q <= 1'b1;
        end
    end

    assign bus.alu_a    = alu_a_q;
    assign bus.alu_b    = alu_b_q;
    assign bus.alu_op   = alu_op_q;
    assign bus.alu_en   = alu_en_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.cmd_err  = cmd_err_q;
    assign bus.busy     = (state != IDLE);

endmodule
